render_fetch: RTL and testbench
===============================

# render_fetch

Upstream feeder for the colour mapper: converts the VGA controller's pixel coordinates into the per-pixel render flags `renderSugar`, `renderNest`, `renderAnt` and `renderSignal`. During each horizontal blank it scans the ant table and builds a one-row ant-occupancy bitmap for the upcoming grid row. During active video it reads the signal/sugar grid RAM and registers aligned render flags two cycles after the coordinates are presented.

## Interface
Parameters:
- `CELL_SHIFT`, 2: pixel-to-grid shift; each cell is 4×4 pixels.
- `GRID_W`, 160: grid columns.
- `GRID_H`, 120: grid rows.
- `N_ANTS`, 64: ant table depth.
- `NEST_CX`, 80: nest centre column.
- `NEST_CY`, 60: nest centre row.
- `NEST_R`, 3: nest half-width in cells; the nest is a square.

Ports (clock and reset first):
- Clock and reset: one clock, `Clk`; reset `Reset` is asynchronous, active-high.
- `Clk`  in  1  pixel clock.
- `Reset`  in  1  async active-high reset.
- `DrawX`  in  10  pixel column from the VGA controller.
- `DrawY`  in  10  pixel row.
- `draw_valid_in`  in  1  `DrawX`/`DrawY` lie in active video.
- `hblank_start`  in  1  one-cycle pulse at the start of horizontal blank.
- `next_row`  in  7  grid row of the line following this blank.
- `ant_addr`  out  6  ant table read address.
- `ant_x`  in  8  ant grid column; synchronous read, valid 1 cycle after `ant_addr`.
- `ant_y`  in  7  ant grid row; same timing.
- `ant_alive`  in  1  ant entry live; same timing.
- `sig_addr`  out  15  grid RAM address, `row*GRID_W + col`.
- `sig_data`  in  SIGNAL_bits  chemical level; valid 1 cycle after `sig_addr`.
- `sugar_data`  in  1  sugar present in the cell; same timing.
- `renderSugar`, `renderNest`, `renderAnt`  out  1 each  render flags.
- `renderSignal`  out  SIGNAL_bits  chemical level for this pixel.
- `draw_valid_out`  out  1  `draw_valid_in` delayed 2 cycles.
- `scan_overrun`  out  1  sticky: a scan was cut short.

## Operation
- Reset values:
  - All outputs 0, including `ant_addr`, `sig_addr`, `scan_overrun`.
  - Both row bitmaps are cleared.
  - FSM is in IDLE; the front-buffer select is 0.
- Ant-row FSM states: IDLE, CLEAR, SCAN, DRAIN, SWAP.
  - IDLE: on `hblank_start`, latch `next_row` and go to CLEAR.
  - CLEAR (1 cycle): zero the back bitmap (`GRID_W` bits); set `ant_addr`=0.
  - SCAN: issue `ant_addr` 0..N_ANTS-1, one per cycle. Each returned entry sets back bit `ant_x` when all of these hold:
    - `ant_alive`=1;
    - `ant_y` equals the latched row;
    - `ant_x` < `GRID_W`.
  - DRAIN (1 cycle): consume the last returned entry.
  - SWAP (1 cycle): toggle the front-buffer select, then return to IDLE.
- Total scan cost is N_ANTS+3 cycles (67 at default), well inside the 160-cycle blank.
- Multiple ants in one cell OR together. Duplicate entries are harmless.
- `hblank_start` while in CLEAR, SCAN or DRAIN: abort and restart at CLEAR with the new `next_row`. The front buffer is not swapped. Set `scan_overrun`.
- `hblank_start` in the same cycle as SWAP: the swap completes and the FSM goes straight to CLEAR. This is not an overrun.
- Pixel path:
  - Stage 0 (combinational): `col = DrawX>>CELL_SHIFT`, `row = DrawY>>CELL_SHIFT`.
    - `sig_addr` is registered as `(row<<7)+(row<<5)+col`, 15 bits. Maximum 19199.
    - A pixel is forced invalid when `DrawX`≥640 or `DrawY`≥480.
  - Stage 1 registers:
    - valid;
    - nest flag: `|col-NEST_CX|≤NEST_R` and `|row-NEST_CY|≤NEST_R`, computed as signed 11-bit differences;
    - front-bitmap bit at `col`.
  - Stage 2 registers the outputs: `renderSignal`=`sig_data`, `renderSugar`=`sugar_data`, plus the nest and ant flags.
  - An invalid pixel produces all render outputs 0 at stage 2.

## Timing
- Pixel latency is exactly 2 cycles: a coordinate presented at cycle t produces outputs at t+2. `draw_valid_out` matches.
- `sig_addr` is updated every cycle, including during blank.
- The front bitmap changes only in SWAP, which lies in blank, so no visible tearing.
- Reset asserted mid-scan: immediate return to IDLE with bitmaps cleared. The next `hblank_start` restarts normally.

## Configuration
- `SCAN_OVERRUN_FLAG_EN`:
  - Defined: `scan_overrun` is a sticky register, cleared only by `Reset`.
  - Undefined: `scan_overrun` is tied to 0 and the register is not built. Abort/restart behaviour is unchanged.

## Structure
- Shared `params` package holds:
  - `SIGNAL_bits` (17), `SIGNAL_DISP_MIN`/`SIGNAL_DISP_MAX`;
  - grid dimension constants;
  - FSM state enum `ant_scan_state_t`.
- One sub-module, `ant_row_scanner`, contains the FSM, both bitmaps and the front select. It exports a combinational front-bit read at `col`.

## Test plan
- Reset, then `DrawX`=0, `DrawY`=0 valid with `sig_data`=100 → 2 cycles later `renderSignal`=100, all flags 0 (nest away from origin), `draw_valid_out`=1.
- Ant 5 live at (10,7), `next_row`=7 pulsed in blank, then line `DrawY`=28, `DrawX`=40..43 → `renderAnt`=1 for those 4 pixels only; 0 at `DrawX`=44.
- Same ant with `ant_alive`=0, or `ant_x`=200 → `renderAnt`=0 across the whole row.
- `DrawX`=320, `DrawY`=240 (cell 80,60) → `renderNest`=1; cell 84,60 → 0. `sig_addr` for cell (159,119) = 19199.
- Second `hblank_start` 20 cycles after the first → FSM restarts at CLEAR, `scan_overrun`=1 (0 with macro undefined), front bitmap unchanged until the completed SWAP.
- `Reset` asserted during SCAN → all outputs 0 next cycle, FSM IDLE. Next blank pulse builds a correct bitmap.

Source files
------------

// File: rtl/params.sv
// Shared constants, grid geometry and ant-scan state encoding
// for the render_fetch pixel feeder.
package params;

  localparam int SIGNAL_bits     = 17;
  localparam int SIGNAL_DISP_MIN = 0;
  localparam int SIGNAL_DISP_MAX = (1 << SIGNAL_bits) - 1;

  localparam int GRID_COLS = 160;
  localparam int GRID_ROWS = 120;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN,
    S_DRAIN,
    S_SWAP
  } ant_scan_state_t;

endpackage

// File: rtl/ant_row_scanner.sv
// Builds the ant-occupancy bitmap for one grid row during hblank.
// Optional sticky overrun flag: SCAN_OVERRUN_FLAG_EN.
module ant_row_scanner
  import params::*;
#(
  parameter int GRID_W = 160,
  parameter int N_ANTS = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       hblank_start,
  input  logic [6:0] next_row,
  input  logic [7:0] ant_x,
  input  logic [6:0] ant_y,
  input  logic       ant_alive,
  input  logic [7:0] rd_col,
  output logic [5:0] ant_addr,
  output logic       front_bit,
  output logic       scan_overrun
);

  ant_scan_state_t   state;
  logic [GRID_W-1:0] bmp [2];
  logic              front_sel;
  logic [6:0]        row_q;
  logic              abort;
  logic              hit;

  assign abort = hblank_start &&
                 (state inside {S_CLEAR, S_SCAN, S_DRAIN});

  assign hit = ant_alive && (ant_y == row_q) &&
               (int'(ant_x) < GRID_W);

  // Front row read for the pixel path; off-grid columns read 0.
  assign front_bit = (int'(rd_col) < GRID_W) ?
                     bmp[front_sel][rd_col] : 1'b0;

  // Scan FSM: clear back row, sweep the ant table, then swap.
  // Every entry seen in SCAN/DRAIN is a real table entry, so any
  // overlap between issue and return just ORs a duplicate in.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      front_sel <= 1'b0;
      row_q     <= '0;
      ant_addr  <= '0;
      bmp[0]    <= '0;
      bmp[1]    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hblank_start) begin
            row_q <= next_row;
            state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          bmp[~front_sel] <= '0;
          ant_addr        <= '0;
          state           <= S_SCAN;
        end
        S_SCAN: begin
          if (hit) bmp[~front_sel][ant_x] <= 1'b1;
          ant_addr <= ant_addr + 6'd1;
          if (ant_addr == 6'(N_ANTS - 1))
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (hit) bmp[~front_sel][ant_x] <= 1'b1;
          state <= S_SWAP;
        end
        S_SWAP: begin
          front_sel <= ~front_sel;
          if (hblank_start) begin
            row_q <= next_row;
            state <= S_CLEAR;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (abort) begin
        row_q <= next_row;
        state <= S_CLEAR;
      end
    end
  end

`ifdef SCAN_OVERRUN_FLAG_EN
  // Sticky: a new blank arrived before the previous scan finished.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)      scan_overrun <= 1'b0;
    else if (abort) scan_overrun <= 1'b1;
  end
`else
  assign scan_overrun = 1'b0;
`endif

endmodule

// File: rtl/render_fetch.sv
// Pixel-coordinate to render-flag pipeline (2-cycle latency).
// Optional sticky overrun flag: SCAN_OVERRUN_FLAG_EN.
module render_fetch
  import params::*;
#(
  parameter int CELL_SHIFT = 2,
  parameter int GRID_W     = 160,
  parameter int GRID_H     = 120,
  parameter int N_ANTS     = 64,
  parameter int NEST_CX    = 80,
  parameter int NEST_CY    = 60,
  parameter int NEST_R     = 3
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic                   draw_valid_in,
  input  logic                   hblank_start,
  input  logic [6:0]             next_row,
  output logic [5:0]             ant_addr,
  input  logic [7:0]             ant_x,
  input  logic [6:0]             ant_y,
  input  logic                   ant_alive,
  output logic [14:0]            sig_addr,
  input  logic [SIGNAL_bits-1:0] sig_data,
  input  logic                   sugar_data,
  output logic                   renderSugar,
  output logic                   renderNest,
  output logic                   renderAnt,
  output logic [SIGNAL_bits-1:0] renderSignal,
  output logic                   draw_valid_out,
  output logic                   scan_overrun
);

  logic [9:0]         col0;
  logic [9:0]         row0;
  logic [14:0]        addr0;
  logic               v0;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic signed [10:0] lim;
  logic               nest0;
  logic               front_bit;

  logic v1;
  logic dv1;
  logic nest1;
  logic ant1;

  assign col0 = DrawX >> CELL_SHIFT;
  assign row0 = DrawY >> CELL_SHIFT;

  assign addr0 = ({5'b0, row0} << 7) + ({5'b0, row0} << 5) +
                 {5'b0, col0};

  assign v0 = draw_valid_in &&
              (DrawX < 10'(H_ACTIVE)) &&
              (DrawY < 10'(V_ACTIVE)) &&
              (int'(col0) < GRID_W) &&
              (int'(row0) < GRID_H);

  assign dx    = 11'({1'b0, col0}) - 11'(NEST_CX);
  assign dy    = 11'({1'b0, row0}) - 11'(NEST_CY);
  assign lim   = 11'(NEST_R);
  assign nest0 = (dx >= -lim) && (dx <= lim) &&
                 (dy >= -lim) && (dy <= lim);

  ant_row_scanner #(
    .GRID_W (GRID_W),
    .N_ANTS (N_ANTS)
  ) u_scan (
    .Clk          (Clk),
    .Reset        (Reset),
    .hblank_start (hblank_start),
    .next_row     (next_row),
    .ant_x        (ant_x),
    .ant_y        (ant_y),
    .ant_alive    (ant_alive),
    .rd_col       (col0[7:0]),
    .ant_addr     (ant_addr),
    .front_bit    (front_bit),
    .scan_overrun (scan_overrun)
  );

  // Stage 1: RAM address plus per-pixel flags awaiting RAM data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sig_addr <= '0;
      v1       <= 1'b0;
      dv1      <= 1'b0;
      nest1    <= 1'b0;
      ant1     <= 1'b0;
    end else begin
      sig_addr <= addr0;
      v1       <= v0;
      dv1      <= draw_valid_in;
      nest1    <= nest0;
      ant1     <= front_bit;
    end
  end

  // Stage 2: aligned outputs; invalid pixels render nothing.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      renderSignal   <= '0;
      renderSugar    <= 1'b0;
      renderNest     <= 1'b0;
      renderAnt      <= 1'b0;
      draw_valid_out <= 1'b0;
    end else begin
      renderSignal   <= v1 ? sig_data : '0;
      renderSugar    <= v1 & sugar_data;
      renderNest     <= v1 & nest1;
      renderAnt      <= v1 & ant1;
      draw_valid_out <= dv1;
    end
  end

endmodule

// File: tb/tb_render_fetch.sv
// Randomized self-checking bench for render_fetch against an
// occupancy/geometry reference model.
module tb_render_fetch;
  import params::*;

`ifdef SCAN_OVERRUN_FLAG_EN
  localparam bit EXP_OVR = 1'b1;
`else
  localparam bit EXP_OVR = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        draw_valid_in, hblank_start;
  logic [6:0]  next_row;
  logic [5:0]  ant_addr;
  logic [7:0]  ant_x;
  logic [6:0]  ant_y;
  logic        ant_alive;
  logic [14:0] sig_addr;
  logic [16:0] sig_data;
  logic        sugar_data;
  logic        renderSugar, renderNest, renderAnt;
  logic [16:0] renderSignal;
  logic        draw_valid_out, scan_overrun;

  render_fetch dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .draw_valid_in  (draw_valid_in),
    .hblank_start   (hblank_start),
    .next_row       (next_row),
    .ant_addr       (ant_addr),
    .ant_x          (ant_x),
    .ant_y          (ant_y),
    .ant_alive      (ant_alive),
    .sig_addr       (sig_addr),
    .sig_data       (sig_data),
    .sugar_data     (sugar_data),
    .renderSugar    (renderSugar),
    .renderNest     (renderNest),
    .renderAnt      (renderAnt),
    .renderSignal   (renderSignal),
    .draw_valid_out (draw_valid_out),
    .scan_overrun   (scan_overrun)
  );

  always #5 Clk = ~Clk;

  function automatic logic [16:0] sig_fn(input int a);
    return 17'((a * 37 + 100) % 131072);
  endfunction

  function automatic logic sug_fn(input int a);
    return 1'(((a * 13) >> 3) & 1);
  endfunction

  // Grid RAM read port follows the registered address.
  assign sig_data   = sig_fn(int'(sig_addr));
  assign sugar_data = sug_fn(int'(sig_addr));

  // Ant table with a synchronous read port.
  logic [7:0] tx [64];
  logic [6:0] ty [64];
  logic       ta [64];

  always @(posedge Clk) begin
    ant_x     <= tx[ant_addr];
    ant_y     <= ty[ant_addr];
    ant_alive <= ta[ant_addr];
  end

  typedef struct {
    logic [16:0] sig;
    logic        sug;
    logic        nest;
    logic        ant;
    logic        dv;
  } exp_t;

  exp_t q[$];
  bit   front [160];
  bit   pend  [160];
  int   cnt;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Which columns of row r hold at least one live on-grid ant.
  task automatic build(input int r);
    foreach (pend[c]) pend[c] = 1'b0;
    for (int i = 0; i < 64; i++)
      if (ta[i] && int'(ty[i]) == r && int'(tx[i]) < 160)
        pend[tx[i]] = 1'b1;
  endtask

  task automatic tick(input int x, input int y, input bit v,
                      input bit hb, input int nr);
    exp_t e;
    int   col, row, dx, dy;
    bit   ok;
    DrawX         = 10'(x);
    DrawY         = 10'(y);
    draw_valid_in = v;
    hblank_start  = hb;
    next_row      = 7'(nr);
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) front = pend;
    end
    col    = x >> 2;
    row    = y >> 2;
    dx     = col - 80;
    dy     = row - 60;
    ok     = v && x < 640 && y < 480;
    e.dv   = v;
    e.sig  = ok ? sig_fn(row * 160 + col) : 17'd0;
    e.sug  = ok ? sug_fn(row * 160 + col) : 1'b0;
    e.nest = ok && dx >= -3 && dx <= 3 && dy >= -3 && dy <= 3;
    e.ant  = (ok && col < 160) ? front[col] : 1'b0;
    if (hb) begin
      build(nr);
      cnt = 68;
    end
    q.push_back(e);
    @(posedge Clk);
    #1;
    hblank_start = 1'b0;
    check("sig_addr", 32'(sig_addr), 32'((row * 160 + col) % 32768));
    if (q.size() == 2) begin
      e = q.pop_front();
      check("renderSignal", 32'(renderSignal), 32'(e.sig));
      check("renderSugar", 32'(renderSugar), 32'(e.sug));
      check("renderNest", 32'(renderNest), 32'(e.nest));
      check("renderAnt", 32'(renderAnt), 32'(e.ant));
      check("draw_valid_out", 32'(draw_valid_out), 32'(e.dv));
    end
  endtask

  task automatic blank(input int r);
    tick(700, 0, 1'b0, 1'b1, r);
    repeat (79) tick(700, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic line(input int y);
    for (int x = 0; x < 640; x++) tick(x, y, 1'b1, 1'b0, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sig"}, 32'(renderSignal), 0);
    check({tag, "_flags"},
          32'({renderSugar, renderNest, renderAnt, draw_valid_out}), 0);
    check({tag, "_ant_addr"}, 32'(ant_addr), 0);
    check({tag, "_sig_addr"}, 32'(sig_addr), 0);
    check({tag, "_ovr"}, 32'(scan_overrun), 0);
  endtask

  task automatic model_reset();
    q.delete();
    cnt = 0;
    foreach (front[c]) front[c] = 1'b0;
  endtask

  task automatic rand_table();
    for (int i = 0; i < 64; i++) begin
      tx[i] = 8'($urandom_range(0, 255));
      ty[i] = 7'($urandom_range(0, 127));
      ta[i] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int r, r2;
    Reset         = 1'b1;
    DrawX         = '0;
    DrawY         = '0;
    draw_valid_in = 1'b0;
    hblank_start  = 1'b0;
    next_row      = '0;
    rand_table();
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_zero("reset");
    Reset = 1'b0;

    // Origin pixel: signal 100, no flags.
    tick(0, 0, 1'b1, 1'b0, 0);
    tick(1, 0, 1'b1, 1'b0, 0);
    tick(2, 0, 1'b1, 1'b0, 0);
    check("origin_sig", 32'(renderSignal), 100);

    // Single ant 5 at (10,7) on row 7.
    rand_table();
    for (int i = 0; i < 64; i++) if (ty[i] == 7'd7) ty[i] = 7'd8;
    tx[5] = 8'd10; ty[5] = 7'd7; ta[5] = 1'b1;
    blank(7);
    line(28);
    blank(7);
    check("no_ovr", 32'(scan_overrun), 0);

    // Dead ant, then off-grid ant.
    ta[5] = 1'b0;
    blank(7);
    line(28);
    ta[5] = 1'b1; tx[5] = 8'd200;
    blank(7);
    line(28);

    // Random tables with a crowded target row.
    repeat (4) begin
      rand_table();
      r = $urandom_range(0, 119);
      for (int i = 0; i < 24; i++) begin
        ty[$urandom_range(0, 63)] = 7'(r);
        tx[$urandom_range(0, 63)] = 8'($urandom_range(0, 170));
      end
      blank(r);
      repeat (300)
        tick($urandom_range(0, 700), r * 4 + $urandom_range(0, 3),
             1'($urandom_range(0, 3) != 0), 1'b0, 0);
      repeat (20)
        tick($urandom_range(0, 1023), $urandom_range(470, 1023),
             1'b1, 1'b0, 0);
    end

    // Nest edges and the far corner address.
    tick(320, 240, 1'b1, 1'b0, 0);
    tick(336, 240, 1'b1, 1'b0, 0);
    tick(332, 252, 1'b1, 1'b0, 0);
    tick(332, 256, 1'b1, 1'b0, 0);
    tick(636, 476, 1'b1, 1'b0, 0);
    check("sig_addr_max", 32'(sig_addr), 19199);
    tick(0, 0, 1'b0, 1'b0, 0);
    tick(0, 0, 1'b0, 1'b0, 0);

    // Overrun: second blank 20 cycles into the first scan.
    rand_table();
    r  = $urandom_range(0, 119);
    r2 = $urandom_range(0, 119);
    for (int i = 0; i < 16; i++) ty[i] = 7'(r2);
    tick(700, 0, 1'b0, 1'b1, r);
    repeat (19) tick($urandom_range(0, 639), 4 * r, 1'b1, 1'b0, 0);
    tick(700, 0, 1'b0, 1'b1, r2);
    check("overrun", 32'(scan_overrun), 32'(EXP_OVR));
    repeat (70) tick($urandom_range(0, 639), 4 * r2, 1'b1, 1'b0, 0);
    line(4 * r2 + 1);

    // Reset in the middle of a scan.
    r = $urandom_range(0, 119);
    for (int i = 16; i < 32; i++) ty[i] = 7'(r);
    tick(700, 0, 1'b0, 1'b1, r);
    repeat (10) tick(700, 0, 1'b0, 1'b0, 0);
    Reset = 1'b1;
    #1;
    check_zero("mid_reset");
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
    line(4 * r);
    blank(r);
    line(4 * r + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
